pipeline_perf_counter_bank: RTL and testbench

Parametrised multi-channel performance counter bank for the pipelined core: a free-running cycle counter plus NUM_EVENTS event counters (stalls, mispredicts, flushes, etc.).
- Run/halt control FSM, synchronous clear, and per-channel wrap or saturate overflow with sticky flags.
- Atomic snapshot into shadow registers, read back through an addressed, registered read port.
- Sits beside the pipeline control logic; event inputs are single-cycle strobes from hazard/branch units.

---
 rtl/pipeline_perf_counter_bank.sv | 122 ++++++++++++
 tb/tb_pipeline_perf_counter_bank.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_perf_counter_bank.sv
// Performance counter bank: free-running cycle counter plus NUM_EVENTS event counters,
// run/halt control, sticky overflow flags, atomic snapshot and registered read port.
module pipeline_perf_counter_bank #(
   parameter  int unsigned NUM_EVENTS = 4,
   parameter  int unsigned CNT_W      = 32,
   parameter  int unsigned SATURATE   = 0,
   localparam int unsigned AW         = $clog2(NUM_EVENTS + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  clear,
   input  logic [NUM_EVENTS-1:0] events,
   input  logic                  snap,
   input  logic [AW-1:0]         rd_addr,
   output logic [CNT_W-1:0]      rd_data,
   output logic                  rd_ovf,
   output logic                  running,
   output logic                  ovf_any
);

   localparam int unsigned NCH = NUM_EVENTS + 1;

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t           state_q, state_n;
   logic [CNT_W-1:0] cnt_q [NCH];
   logic [CNT_W-1:0] sh_q  [NCH];
   logic [NCH-1:0]   ovf_q;
   logic [NCH-1:0]   sh_ovf_q;
   logic [NCH-1:0]   inc;
   logic [CNT_W-1:0] rd_data_n;
   logic             rd_ovf_n;

   // Next state: clear beats stop beats start
   always_comb begin
      state_n = state_q;
      if (clear) begin
         state_n = IDLE;
      end else if (stop) begin
         if (state_q == RUN) state_n = HALT;
      end else if (start && state_q != RUN) begin
         state_n = RUN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         running <= 1'b0;
      end else begin
         state_q <= state_n;
         running <= (state_n == RUN);
      end
   end

   // Increments are qualified by the pre-edge state only
   always_comb begin
      inc    = '0;
      inc[0] = (state_q == RUN);
      for (int unsigned i = 1; i < NCH; i++) begin
         inc[i] = (state_q == RUN) && events[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NCH; i++) cnt_q[i] <= '0;
         ovf_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NCH; i++) begin
            if (clear) begin
               cnt_q[i] <= '0;
               ovf_q[i] <= 1'b0;
            end else if (inc[i]) begin
               if (&cnt_q[i]) begin
                  ovf_q[i] <= 1'b1;
                  if (SATURATE == 0) cnt_q[i] <= '0;
               end else begin
                  cnt_q[i] <= cnt_q[i] + CNT_W'(1);
               end
            end
         end
      end
   end

   // Shadows capture pre-update live values, so snap+clear keeps the old counts
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NCH; i++) sh_q[i] <= '0;
         sh_ovf_q <= '0;
      end else if (snap) begin
         for (int unsigned i = 0; i < NCH; i++) sh_q[i] <= cnt_q[i];
         sh_ovf_q <= ovf_q;
      end
   end

   always_comb begin
      rd_data_n = '0;
      rd_ovf_n  = 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (rd_addr == AW'(i)) begin
            rd_data_n = sh_q[i];
            rd_ovf_n  = sh_ovf_q[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
         rd_ovf  <= 1'b0;
         ovf_any <= 1'b0;
      end else begin
         rd_data <= rd_data_n;
         rd_ovf  <= rd_ovf_n;
         ovf_any <= |ovf_q;
      end
   end

endmodule

// File: tb/tb_pipeline_perf_counter_bank.sv
// Bench for pipeline_perf_counter_bank: wrapping and saturating instances (CNT_W=8) driven
// in lockstep, checked against a cycle model through a scoreboard queue plus direct checks.
module tb_pipeline_perf_counter_bank;

   localparam int unsigned NE   = 4;
   localparam int unsigned CW   = 8;
   localparam int unsigned NCH  = NE + 1;
   localparam int unsigned AW   = 3;
   localparam int unsigned MAXV = 255;
   localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

   logic          clk, rst, start, stop, clear, snap;
   logic [NE-1:0] events;
   logic [AW-1:0] rd_addr;
   logic [CW-1:0] rd_data0, rd_data1;
   logic          rd_ovf0, rd_ovf1, running0, running1, ovf_any0, ovf_any1;

   pipeline_perf_counter_bank #(.NUM_EVENTS(NE), .CNT_W(CW), .SATURATE(0)) u_wrap (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .events(events),
      .snap(snap), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_ovf(rd_ovf0),
      .running(running0), .ovf_any(ovf_any0));

   pipeline_perf_counter_bank #(.NUM_EVENTS(NE), .CNT_W(CW), .SATURATE(1)) u_sat (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .events(events),
      .snap(snap), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_ovf(rd_ovf1),
      .running(running1), .ovf_any(ovf_any1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        run;
      logic        oa0, oa1;
      int unsigned rd0, rd1;
      logic        ro0, ro1;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic          st, sp, cl;
      logic [NE-1:0] ev;
      logic          sn;
      logic [AW-1:0] a;
      logic          x_run;
      int unsigned   x_rd;
   } vec_t;
   vec_t tbl[16];

   // Cycle model, one copy per instance (index 0 wraps, 1 saturates)
   int          m_state;
   int unsigned m_cnt [2][NCH];
   logic        m_ovf [2][NCH];
   int unsigned m_sh  [2][NCH];
   logic        m_sho [2][NCH];

   task automatic model_reset();
      m_state = M_IDLE;
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < int'(NCH); i++) begin
            m_cnt[d][i] = 0; m_ovf[d][i] = 1'b0; m_sh[d][i] = 0; m_sho[d][i] = 1'b0;
         end
   endtask

   task automatic model_edge(input logic st, input logic sp, input logic cl,
                             input logic [NE-1:0] ev, input logic sn,
                             input logic [AW-1:0] a, output exp_t e);
      int unsigned rd [2];
      logic        ro [2];
      logic        oa [2];
      logic        inc;
      for (int d = 0; d < 2; d++) begin
         rd[d] = 0; ro[d] = 1'b0; oa[d] = 1'b0;
         for (int i = 0; i < int'(NCH); i++) begin
            if (int'(a) == i) begin rd[d] = m_sh[d][i]; ro[d] = m_sho[d][i]; end
            oa[d] = oa[d] | m_ovf[d][i];
         end
         if (sn)
            for (int i = 0; i < int'(NCH); i++) begin
               m_sh[d][i] = m_cnt[d][i]; m_sho[d][i] = m_ovf[d][i];
            end
         for (int i = 0; i < int'(NCH); i++) begin
            inc = (m_state == M_RUN) && (i == 0 || ev[i-1] == 1'b1);
            if (cl) begin
               m_cnt[d][i] = 0; m_ovf[d][i] = 1'b0;
            end else if (inc) begin
               if (m_cnt[d][i] == MAXV) begin
                  m_ovf[d][i] = 1'b1;
                  m_cnt[d][i] = (d == 1) ? MAXV : 0;
               end else begin
                  m_cnt[d][i] = m_cnt[d][i] + 1;
               end
            end
         end
      end
      if (cl) m_state = M_IDLE;
      else if (sp) begin if (m_state == M_RUN) m_state = M_HALT; end
      else if (st) m_state = M_RUN;
      e.run = (m_state == M_RUN);
      e.oa0 = oa[0]; e.oa1 = oa[1];
      e.rd0 = rd[0]; e.rd1 = rd[1];
      e.ro0 = ro[0]; e.ro1 = ro[1];
   endtask

   task automatic chk(input string nm, input longint unsigned got, input longint unsigned exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
      end
   endtask

   // Drive one cycle, predict its outcome, then compare after the edge
   task automatic step(input logic st, input logic sp, input logic cl,
                       input logic [NE-1:0] ev, input logic sn, input logic [AW-1:0] a);
      exp_t e, p;
      start = st; stop = sp; clear = cl; events = ev; snap = sn; rd_addr = a;
      model_edge(st, sp, cl, ev, sn, a, e);
      sb.push_back(e);
      @(posedge clk);
      #1;
      p = sb.pop_front();
      chk("sb_running0", running0, p.run);
      chk("sb_running1", running1, p.run);
      chk("sb_ovf_any0", ovf_any0, p.oa0);
      chk("sb_ovf_any1", ovf_any1, p.oa1);
      chk("sb_rd_data0", rd_data0, p.rd0);
      chk("sb_rd_data1", rd_data1, p.rd1);
      chk("sb_rd_ovf0",  rd_ovf0,  p.ro0);
      chk("sb_rd_ovf1",  rd_ovf1,  p.ro1);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_rd_data0"}, rd_data0, 0); chk({nm, "_rd_data1"}, rd_data1, 0);
      chk({nm, "_rd_ovf0"},  rd_ovf0,  0); chk({nm, "_rd_ovf1"},  rd_ovf1,  0);
      chk({nm, "_running0"}, running0, 0); chk({nm, "_running1"}, running1, 0);
      chk({nm, "_ovf_any0"}, ovf_any0, 0); chk({nm, "_ovf_any1"}, ovf_any1, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // start, 10 counted cycles with 3 events, stop, snap, read back
      //            st    sp    cl    ev       sn    a     run   rd
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b1, 0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 3'd0, 1'b1, 0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b1, 0};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 3'd0, 1'b1, 0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b1, 0};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 3'd0, 1'b1, 0};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b1, 0};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b1, 0};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b1, 0};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b1, 0};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 0};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd0, 1'b0, 0};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 10};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd1, 1'b0, 3};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd5, 1'b0, 0};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd7, 1'b0, 0};

      rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; snap = 1'b0;
      events = '0; rd_addr = '0;
      model_reset();
      #12;
      chk_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      for (int k = 0; k < 16; k++) begin
         step(tbl[k].st, tbl[k].sp, tbl[k].cl, tbl[k].ev, tbl[k].sn, tbl[k].a);
         chk($sformatf("tbl%0d_running", k), running0, tbl[k].x_run);
         chk($sformatf("tbl%0d_rd_data", k), rd_data0, tbl[k].x_rd);
      end

      // start+stop together: RUN -> HALT, IDLE stays IDLE and does not count
      step(1, 0, 0, 4'h0, 0, 0);
      chk("resume_running", running0, 1);
      step(1, 1, 0, 4'h0, 0, 0);
      chk("ststop_run_halt", running0, 0);
      step(0, 0, 1, 4'h0, 0, 0);
      step(1, 1, 0, 4'hF, 0, 0);
      chk("ststop_idle", running0, 0);
      step(0, 0, 0, 4'hF, 0, 0);
      step(0, 0, 0, 4'h0, 1, 0);
      step(0, 0, 0, 4'h0, 0, 0);
      chk("idle_no_count_cyc", rd_data0, 0);
      step(0, 0, 0, 4'h0, 0, 1);
      chk("idle_no_count_ev", rd_data0, 0);

      // 256 counted cycles from zero: wrap vs saturate, sticky flag, lagging ovf_any
      step(0, 0, 1, 4'h0, 0, 0);
      step(1, 0, 0, 4'h0, 0, 0);
      repeat (255) step(0, 0, 0, 4'h0, 0, 0);
      step(0, 1, 0, 4'h0, 0, 0);
      chk("wrap_stopped", running0, 0);
      chk("ovf_any_lag", ovf_any0, 0);
      step(0, 0, 0, 4'h0, 1, 0);
      chk("ovf_any_wrap", ovf_any0, 1);
      chk("ovf_any_sat", ovf_any1, 1);
      step(0, 0, 0, 4'h0, 0, 0);
      chk("wrap_cnt", rd_data0, 0);
      chk("wrap_ovf", rd_ovf0, 1);
      chk("sat_cnt", rd_data1, 255);
      chk("sat_ovf", rd_ovf1, 1);
      step(0, 0, 0, 4'h0, 0, 1);
      chk("ch1_no_ovf", rd_ovf0, 0);

      // snap and clear in the same cycle with channel 1 at 7
      step(0, 0, 1, 4'h0, 0, 0);
      step(1, 0, 0, 4'h0, 0, 0);
      repeat (7) step(0, 0, 0, 4'b0001, 0, 0);
      step(0, 0, 1, 4'h0, 1, 1);
      chk("snapclr_idle", running0, 0);
      step(0, 0, 0, 4'h0, 0, 1);
      chk("snapclr_shadow0", rd_data0, 7);
      chk("snapclr_shadow1", rd_data1, 7);
      chk("snapclr_flags", ovf_any0, 0);
      step(0, 0, 0, 4'h0, 1, 1);
      step(0, 0, 0, 4'h0, 0, 1);
      chk("snapclr_live0", rd_data0, 0);

      // asynchronous reset between edges while running with a non-zero read value
      step(1, 0, 0, 4'h0, 0, 0);
      repeat (3) step(0, 0, 0, 4'b0010, 0, 2);
      step(0, 0, 0, 4'h0, 1, 2);
      step(0, 0, 0, 4'h0, 0, 2);
      chk("pre_rst_rd", rd_data0, 3);
      #2;
      rst = 1'b1;
      #1;
      chk_all_zero("async_rst");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      sb.delete();
      step(0, 0, 0, 4'h0, 0, 2);
      chk("rst_shadow", rd_data0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
